// File: rtl/gate_check_pkg.sv
// Shared types and constants for the 2-input gate truth-table checker.
// Truth tables are indexed by {a,b}: bit i is the required output for vector i.
package gate_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int NUM_VECTORS = 4;
    localparam int CNT_W       = 4;

    localparam logic [3:0] TT_XNOR = 4'b1001;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/gate_truth_checker_if.sv
// Stimulus/response bundle between the checker and whoever requests runs.
// The slave side is the checker; the master side starts runs and supplies y_in.
interface gate_truth_checker_if;
    import gate_check_pkg::*;

    logic                   start;
    logic [NUM_VECTORS-1:0] expected;
    logic                   y_in;
    logic                   a_out;
    logic                   b_out;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [NUM_VECTORS-1:0] fail_vec;
    logic [2:0]             err_count;

    modport master (
        output start, expected, y_in,
        input  a_out, b_out, busy, done, pass, fail_vec, err_count
    );

    modport slave (
        input  start, expected, y_in,
        output a_out, b_out, busy, done, pass, fail_vec, err_count
    );

endinterface

// File: rtl/gate_truth_checker.sv
// Walks a 2-input gate through all four input vectors, samples its output after
// a settle delay and compares against a latched truth table.
//
// state  | meaning
// IDLE   | waiting for start; results of the last run held
// SETTLE | vector driven, counting down the settle delay
// SAMPLE | y_in compared with expected[idx] at the end of this cycle
// DONE   | one-cycle done pulse, gate inputs back to 00
module gate_truth_checker
    import gate_check_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gate_truth_checker_if.slave  bus
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [1:0]       IDX_LAST    = 2'(NUM_VECTORS - 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [1:0]             idx_q, idx_d;
    logic [1:0]             ab_q, ab_d;
    logic [NUM_VECTORS-1:0] exp_q, exp_d;
    logic [NUM_VECTORS-1:0] fail_q, fail_d;
    logic                   pass_q, pass_d;
    logic [2:0]             err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            ab_q    <= '0;
            exp_q   <= '0;
            fail_q  <= '0;
            pass_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ab_q    <= ab_d;
            exp_q   <= exp_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        ab_d    = ab_q;
        exp_d   = exp_q;
        fail_d  = fail_q;
        pass_d  = pass_q;
        err_d   = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    exp_d   = bus.expected;
                    idx_d   = '0;
                    ab_d    = '0;
                    fail_d  = '0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    cnt_d   = SETTLE_LOAD;
                    state_d = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_SAMPLE: begin
                if (bus.y_in != exp_q[idx_q]) begin
                    fail_d[idx_q] = 1'b1;
                end
                // Results are finalised from fail_d so the last vector counts.
                if (idx_q == IDX_LAST) begin
                    ab_d    = '0;
                    pass_d  = (fail_d == '0);
                    err_d   = popcount4(fail_d);
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    ab_d    = idx_q + 2'd1;
                    cnt_d   = SETTLE_LOAD;
                    state_d = ST_SETTLE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.a_out     = ab_q[1];
    assign bus.b_out     = ab_q[0];
    assign bus.busy      = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.pass      = pass_q;
    assign bus.fail_vec  = fail_q;
    assign bus.err_count = err_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: two instances (settle 2 and settle 1), a
// cycle-offset reference model per instance, directed and random runs.
module tb_gate_truth_checker;
    import gate_check_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n0, rst_n1;
    logic [3:0] tt0, tt1;
    logic noise0, noise1, nb0, nb1;

    int n_tests = 0;
    int n_fail  = 0;

    gate_truth_checker_if if0();
    gate_truth_checker_if if1();

    gate_truth_checker #(.SETTLE_CYCLES(2)) dut0 (.clk(clk), .rst_n(rst_n0), .bus(if0));
    gate_truth_checker #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n1), .bus(if1));

    assign if0.y_in = noise0 ? nb0 : tt0[{if0.a_out, if0.b_out}];
    assign if1.y_in = noise1 ? nb1 : tt1[{if1.a_out, if1.b_out}];

    always @(posedge clk) begin
        #2;
        nb0 = 1'($urandom);
        nb1 = 1'($urandom);
    end

    // Reference model: phase 0 idle, 1 running (m_cyc = cycle index since accept), 2 done cycle
    localparam int S_OF [2] = '{2, 1};
    int         m_phase [2] = '{0, 0};
    int         m_cyc   [2] = '{0, 0};
    logic [3:0] m_exp   [2] = '{4'h0, 4'h0};
    logic [3:0] m_fail  [2] = '{4'h0, 4'h0};
    logic       m_pass  [2] = '{1'b0, 1'b0};
    logic [2:0] m_err   [2] = '{3'd0, 3'd0};

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic model_step(input int d, input logic rst, input logic st,
                              input logic [3:0] ex, input logic y);
        int s1;
        int v;
        s1 = S_OF[d] + 1;
        if (!rst) begin
            m_phase[d] = 0; m_cyc[d] = 0; m_fail[d] = '0; m_pass[d] = 1'b0; m_err[d] = '0;
        end else begin
            case (m_phase[d])
                0: if (st) begin
                    m_phase[d] = 1; m_cyc[d] = 1; m_exp[d] = ex;
                    m_fail[d] = '0; m_pass[d] = 1'b0; m_err[d] = '0;
                end
                1: begin
                    if (m_cyc[d] % s1 == 0) begin
                        v = m_cyc[d] / s1 - 1;
                        if (y !== m_exp[d][v]) m_fail[d][v] = 1'b1;
                    end
                    if (m_cyc[d] == 4 * s1) begin
                        m_phase[d] = 2;
                        m_pass[d]  = (m_fail[d] == 4'd0);
                        m_err[d]   = 3'($countones(m_fail[d]));
                    end else begin
                        m_cyc[d]++;
                    end
                end
                default: m_phase[d] = 0;
            endcase
        end
    endtask

    task automatic check_outs(input int d, input logic a, input logic b, input logic busy,
                              input logic done, input logic pass, input logic [3:0] fv,
                              input logic [2:0] ec);
        logic [1:0] ab_e;
        logic busy_e, done_e;
        ab_e = 2'b00; busy_e = 1'b0; done_e = 1'b0;
        if (m_phase[d] == 1) begin
            ab_e   = 2'((m_cyc[d] - 1) / (S_OF[d] + 1));
            busy_e = 1'b1;
        end else if (m_phase[d] == 2) begin
            done_e = 1'b1;
        end
        chk(d == 0 ? "outs_dut0" : "outs_dut1",
            16'({a, b, busy, done, pass, fv, ec}),
            16'({ab_e, busy_e, done_e, m_pass[d], m_fail[d], m_err[d]}));
    endtask

    always @(posedge clk or negedge rst_n0) model_step(0, rst_n0, if0.start, if0.expected, if0.y_in);
    always @(posedge clk or negedge rst_n1) model_step(1, rst_n1, if1.start, if1.expected, if1.y_in);

    always @(negedge clk) begin
        check_outs(0, if0.a_out, if0.b_out, if0.busy, if0.done, if0.pass, if0.fail_vec, if0.err_count);
        check_outs(1, if1.a_out, if1.b_out, if1.busy, if1.done, if1.pass, if1.fail_vec, if1.err_count);
    end

    // Starts one run on dut0 and counts edges from acceptance until done.
    task automatic run0(input logic [3:0] ex, input bit disturb, output int lat,
                        output logic p, output logic [3:0] fv, output logic [2:0] ec);
        @(posedge clk); #2;
        if0.start = 1'b1; if0.expected = ex;
        @(posedge clk); #2;
        if0.start = 1'b0;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            #2;
            if (disturb) begin
                if (lat == 4) begin if0.start = 1'b1; if0.expected = ~ex; end
                if (lat == 5) if0.start = 1'b0;
                if (lat == 7) if0.expected = ex ^ 4'b0101;
            end
            #1;
            if (if0.done) break;
        end
        if (lat >= 100) chk("run0_timeout", 16'(lat), 16'd12);
        p = if0.pass; fv = if0.fail_vec; ec = if0.err_count;
    endtask

    task automatic seq0();
        int lat;
        logic p;
        logic [3:0] fv;
        logic [2:0] ec;
        logic [3:0] tabs [6];
        tabs = '{TT_XNOR, TT_XOR, TT_AND, TT_OR, TT_NAND, TT_NOR};

        tt0 = TT_XNOR; noise0 = 1'b0;
        run0(TT_XNOR, 1'b0, lat, p, fv, ec);
        chk("xnor_latency", 16'(lat), 16'd12);
        chk("xnor_pass", 16'({p, fv, ec}), 16'({1'b1, 4'b0000, 3'd0}));

        tt0 = 4'b0000;
        run0(TT_XNOR, 1'b0, lat, p, fv, ec);
        chk("stuck0_result", 16'({p, fv, ec}), 16'({1'b0, 4'b1001, 3'd2}));

        tt0 = TT_XOR;
        run0(TT_XNOR, 1'b0, lat, p, fv, ec);
        chk("xor_vs_xnor", 16'({p, fv, ec}), 16'({1'b0, 4'b1111, 3'd4}));
        run0(4'b0110, 1'b0, lat, p, fv, ec);
        chk("xor_vs_xor", 16'({p, fv, ec}), 16'({1'b1, 4'b0000, 3'd0}));

        tt0 = TT_AND;
        run0(TT_AND, 1'b1, lat, p, fv, ec);
        chk("disturb_latency", 16'(lat), 16'd12);
        chk("disturb_result", 16'({p, fv, ec}), 16'({1'b1, 4'b0000, 3'd0}));

        // Abort in SAMPLE of vector 2 (cycle 9 after acceptance for settle 2)
        tt0 = TT_XNOR;
        @(posedge clk); #2; if0.start = 1'b1; if0.expected = TT_XNOR;
        @(posedge clk); #2; if0.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("pre_reset_vec", 16'({if0.a_out, if0.b_out, if0.busy}), 16'(3'b101));
        #1; rst_n0 = 1'b0;
        #1;
        chk("reset_abort", 16'({if0.a_out, if0.b_out, if0.busy, if0.done, if0.pass,
                                if0.fail_vec, if0.err_count}), 16'd0);
        repeat (3) @(posedge clk);
        #2; rst_n0 = 1'b1;
        run0(TT_XNOR, 1'b0, lat, p, fv, ec);
        chk("post_reset_lat", 16'(lat), 16'd12);
        chk("post_reset_pass", 16'({p, fv, ec}), 16'({1'b1, 4'b0000, 3'd0}));

        for (int i = 0; i < 25; i++) begin
            int mode;
            mode = int'($urandom_range(0, 8));
            noise0 = (mode == 8);
            if (mode < 6) tt0 = tabs[mode];
            else if (mode == 6) tt0 = 4'b0000;
            else tt0 = 4'b1111;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run0(($urandom_range(0, 1) == 1) ? tt0 : 4'($urandom), 1'($urandom),
                 lat, p, fv, ec);
        end
        noise0 = 1'b0;
    endtask

    task automatic seq1();
        int n;
        repeat (4) @(posedge clk);
        #2; rst_n1 = 1'b1;
        tt1 = TT_AND; noise1 = 1'b0;
        @(posedge clk); #2;
        if1.start = 1'b1; if1.expected = TT_AND;
        @(posedge clk);
        n = 0;
        while (n < 100) begin
            @(posedge clk); n++; #3;
            if (if1.done) break;
        end
        chk("held_first_done", 16'(n), 16'd8);
        chk("held_first_pass", 16'({if1.pass, if1.fail_vec, if1.err_count}),
            16'({1'b1, 4'b0000, 3'd0}));
        tt1 = TT_NOR;
        n = 0;
        while (n < 100) begin
            @(posedge clk); n++; #3;
            if (if1.done) break;
        end
        chk("held_period", 16'(n), 16'd10);
        chk("held_second_fail", 16'({if1.pass, if1.fail_vec, if1.err_count}),
            16'({1'b0, 4'b1001, 3'd2}));
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #2;
            if1.expected = 4'($urandom);
            if (c % 7 == 0) tt1 = 4'($urandom);
            noise1 = ($urandom_range(0, 3) == 0);
        end
        if1.start = 1'b0; noise1 = 1'b0;
        repeat (12) @(posedge clk);
    endtask

    initial begin
        rst_n0 = 1'b0; rst_n1 = 1'b0;
        if0.start = 1'b0; if0.expected = 4'h0;
        if1.start = 1'b0; if1.expected = 4'h0;
        tt0 = TT_XNOR; tt1 = TT_XNOR;
        noise0 = 1'b0; noise1 = 1'b0; nb0 = 1'b0; nb1 = 1'b0;
        @(posedge clk); #1;
        chk("reset_outs0", 16'({if0.a_out, if0.b_out, if0.busy, if0.done, if0.pass,
                                if0.fail_vec, if0.err_count}), 16'd0);
        repeat (2) @(posedge clk);
        #2; rst_n0 = 1'b1;
        fork
            seq0();
            seq1();
        join
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, limit %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gate_truth_checker.md
# gate_truth_checker

Self-checking stimulus/response stage for any 2-input logic gate (XNOR, XOR, AND, ...). On `start` it drives the gate inputs through all four combinations, waits a programmable settle time per vector, samples the gate output, and compares it with a 4-bit expected truth table. It sits directly upstream of the gate under test (drives `a`/`b`) and directly downstream of it (consumes `y`). Pass/fail, a per-vector failure mask and an error count are reported for hardware bring-up and for regression benches.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling; legal range 1..15.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request a run; sampled only in IDLE
- `expected`  in  4  truth table; `expected[{a,b}]` is the required `y`; latched on start acceptance
- `y_in`  in  1  gate-under-test output
- `a_out`  out  1  gate input a (MSB of vector index)
- `b_out`  out  1  gate input b (LSB of vector index)
- `busy`  out  1  high in SETTLE and SAMPLE
- `done`  out  1  one-cycle pulse when results are valid
- `pass`  out  1  1 when no vector failed in the last completed run
- `fail_vec`  out  4  bit i set when vector i mismatched
- `err_count`  out  3  popcount of `fail_vec`, 0..4

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: if `start`=1, latch `expected`, set idx=0, `{a_out,b_out}`=00, clear `fail_vec`/`err_count`/`pass`, load settle counter with SETTLE_CYCLES-1, go to SETTLE.
- SETTLE: decrement counter; when counter=0, go to SAMPLE. `a_out`/`b_out` stable.
- SAMPLE: compare `y_in` with latched `expected[idx]`; on mismatch set `fail_vec[idx]`. If idx=3, go to DONE; else idx+1, drive new `{a_out,b_out}`=idx+1, reload counter, go to SETTLE.
- DONE: `done`=1, `pass`=(`fail_vec`==0), `err_count`=popcount. `a_out`/`b_out` return to 0. Next state is IDLE unconditionally.
- `start` outside IDLE is ignored and not queued. `expected` changes after acceptance have no effect.
- Results (`pass`, `fail_vec`, `err_count`) hold until the next accepted start or reset.
- idx is 2 bits; no wrap past 3, and 3 always exits to DONE.

## Timing
- Reset: state IDLE; all outputs 0. This includes `pass`=0 and `fail_vec`=0000.
- A reset asserted mid-run aborts immediately to the reset values. No `done` is produced.
- Each vector occupies SETTLE_CYCLES cycles in SETTLE plus 1 cycle in SAMPLE.
- `y_in` is captured at the rising edge that ends the SAMPLE cycle.
- Latency: from the edge that accepts `start` to the edge that raises `done` is 4·(SETTLE_CYCLES+1) cycles. This is 12 for the default.
- `done` is high for exactly one cycle; `busy` is 0 during that cycle.
- With `start` held high continuously, a new run is accepted in the IDLE cycle after DONE, so `done` pulses every 4·(S+1)+2 cycles.
- `a_out`/`b_out` are registered. They change only on entry to SETTLE and on entry to DONE.

## Structure
- Shared package `gate_check_pkg`:
  - state enum (IDLE, SETTLE, SAMPLE, DONE)
  - `NUM_VECTORS`=4
  - popcount4 function
  - truth-table constants: XNOR=4'b1001, XOR=4'b0110, AND=4'b1000, OR=4'b1110, NAND=4'b0111, NOR=4'b0001
- Single flat module. The settle counter is small enough that no sub-module is warranted.

## Test plan
- Ideal XNOR model on `y_in`, `expected`=4'b1001, start pulse → `a_out`/`b_out` sequence 00,01,10,11 each held 3 cycles; `done` 12 cycles after start; `pass`=1, `fail_vec`=0000, `err_count`=0.
- `y_in` stuck at 0, `expected`=4'b1001 → `fail_vec`=1001, `err_count`=2, `pass`=0.
- XOR model with `expected`=XNOR constant → `fail_vec`=1111, `err_count`=4. Rerun with `expected`=4'b0110 → `pass`=1.
- Start pulsed again at cycle 5 of a run, and `expected` toggled mid-run → ignored; `done` still at cycle 12 with the original result.
- Reset asserted during SAMPLE of vector 2 → outputs 0 immediately, no `done`. A subsequent start gives a full correct run.
- SETTLE_CYCLES=1 with `start` held high → `done` at 8 cycles, then every 10 cycles; results correct on each run.
